// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one trial subtraction per clock, N iterations per result.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned only.
module seq_restoring_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_divisor;

    logic [N:0]    w_remShift;
    logic [N:0]    w_trial;
    logic [N-1:0]  w_remNext;
    logic [N-1:0]  w_qNext;
    logic [N-1:0]  w_quotFinal;
    logic [N-1:0]  w_remFinal;
    logic [N-1:0]  w_dividendMag;
    logic [N-1:0]  w_divisorMag;

    // R < divisor always holds, so the shifted remainder fits in N+1 bits and the
    // trial result's top bit is a clean borrow flag.
    assign w_remShift = {r_rem, r_q[N-1]};
    assign w_trial    = w_remShift - {1'b0, r_divisor};
    assign w_remNext  = w_trial[N] ? w_remShift[N-1:0] : w_trial[N-1:0];
    assign w_qNext    = {r_q[N-2:0], ~w_trial[N]};

`ifdef DIV_SIGNED_EN
    logic r_negQ;
    logic r_negR;

    // The most-negative value maps to itself, which reads correctly as an unsigned magnitude.
    assign w_dividendMag = dividend[N-1] ? -dividend : dividend;
    assign w_divisorMag  = divisor[N-1]  ? -divisor  : divisor;
    assign w_quotFinal   = r_negQ ? -w_qNext   : w_qNext;
    assign w_remFinal    = r_negR ? -w_remNext : w_remNext;
`else
    assign w_dividendMag = dividend;
    assign w_divisorMag  = divisor;
    assign w_quotFinal   = w_qNext;
    assign w_remFinal    = w_remNext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r_count     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
`ifdef DIV_SIGNED_EN
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        r_divisor <= w_divisorMag;
                        r_q       <= w_dividendMag;
                        r_rem     <= '0;
                        r_count   <= '0;
`ifdef DIV_SIGNED_EN
                        r_negQ    <= dividend[N-1] ^ divisor[N-1];
                        r_negR    <= dividend[N-1];
`endif
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            r_state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem   <= w_remNext;
                    r_q     <= w_qNext;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(N - 1)) begin
                        quotient  <= w_quotFinal;
                        remainder <= w_remFinal;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
